// File: rtl/uart_tx_arb.sv
// Round-robin arbiter that feeds one byte at a time from four requesters to a UART transmitter.
// It issues one send_en per grant and then waits for done or for a timeout before it arbitrates again.
module uart_tx_arb #(
  parameter int NREQ  = 4,
  parameter int CNT_W = 24
) (
  input  logic              mclk,
  input  logic              n_reset,
  input  logic              en,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [CNT_W-1:0]  to_max_cnt,
  input  logic              done,
  output logic [NREQ-1:0]   gnt,
  output logic              send_en,
  output logic [7:0]        tr_data,
  output logic              busy,
  output logic [1:0]        last_id,
  output logic              tx_err,
  output logic [15:0]       sent_cnt,
  output logic [1:0]        state_dbg
);

  // Handshake: a requester holds req high (level) until it sees its one-cycle gnt pulse.
  // The byte is captured on the edge that issues gnt. A req still high after gnt is a new request.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             send_q, send_d;
  logic [7:0]       data_q, data_d;
  logic [1:0]       id_q, id_d;
  logic             err_q, err_d;
  logic [15:0]      sent_q, sent_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [1:0] win;
  logic [1:0] idx;
  logic       found;

  // Search starts at ptr and wraps. The first request bit that is set wins.
  always_comb begin
    win   = 2'd0;
    idx   = 2'd0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = ptr_q + 2'(k);
      if (!found && req[idx]) begin
        win   = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = '0;
    send_d  = 1'b0;
    data_d  = data_q;
    id_d    = id_q;
    err_d   = 1'b0;
    sent_d  = sent_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (en && found) begin
          state_d = SEND;
          gnt_d   = NREQ'(1) << win;
          send_d  = 1'b1;
          data_d  = req_data[{win, 3'b000} +: 8];
          id_d    = win;
          ptr_d   = win + 2'd1;
        end
      end
      SEND: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        // If done and the timeout fall on the same cycle, done takes priority.
        if (done) begin
          state_d = IDLE;
          sent_d  = sent_q + 16'd1;
        end else if ((to_max_cnt != '0) && (cnt_q == to_max_cnt - CNT_W'(1))) begin
          state_d = IDLE;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge mclk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      ptr_q   <= 2'd0;
      gnt_q   <= '0;
      send_q  <= 1'b0;
      data_q  <= 8'h00;
      id_q    <= 2'd0;
      err_q   <= 1'b0;
      sent_q  <= 16'd0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      send_q  <= send_d;
      data_q  <= data_d;
      id_q    <= id_d;
      err_q   <= err_d;
      sent_q  <= sent_d;
      cnt_q   <= cnt_d;
    end
  end

  assign gnt       = gnt_q;
  assign send_en   = send_q;
  assign tr_data   = data_q;
  assign busy      = (state_q != IDLE);
  assign last_id   = id_q;
  assign tx_err    = err_q;
  assign sent_cnt  = sent_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: randomised and directed transfers are checked against a transaction-level model
// that tracks the round-robin pointer and the completed-transfer count.
module tb_uart_tx_arb;

  logic        mclk = 1'b0;
  logic        n_reset;
  logic        en;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [23:0] to_max_cnt;
  logic        done;
  logic [3:0]  gnt;
  logic        send_en;
  logic [7:0]  tr_data;
  logic        busy;
  logic [1:0]  last_id;
  logic        tx_err;
  logic [15:0] sent_cnt;
  logic [1:0]  state_dbg;

  uart_tx_arb #(.NREQ(4), .CNT_W(24)) dut (
    .mclk(mclk), .n_reset(n_reset), .en(en), .req(req), .req_data(req_data),
    .to_max_cnt(to_max_cnt), .done(done), .gnt(gnt), .send_en(send_en),
    .tr_data(tr_data), .busy(busy), .last_id(last_id), .tx_err(tx_err),
    .sent_cnt(sent_cnt), .state_dbg(state_dbg)
  );

  always #5 mclk = ~mclk;

  int checks = 0;
  int errors = 0;
  logic [13:0] exp_q[$];
  logic [16:0] end_q[$];
  int          m_ptr  = 0;
  logic [15:0] m_sent = 16'd0;
  logic        busy_prev = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int p);
    for (int k = 0; k < 4; k++)
      if (r[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  // Monitor: compare every send_en and every end of a transfer against the expected queues.
  always @(negedge mclk) begin
    logic [13:0] e;
    logic [16:0] f;
    if (!n_reset) begin
      busy_prev = 1'b0;
    end else begin
      if (send_en) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_send: gnt=%b with no grant expected at %0t", gnt, $time);
        end else begin
          e = exp_q.pop_front();
          check("gnt", 32'(gnt), 32'(e[13:10]));
          check("tr_data", 32'(tr_data), 32'(e[9:2]));
          check("last_id", 32'(last_id), 32'(e[1:0]));
          check("busy_in_send", 32'(busy), 32'd1);
        end
      end else if (gnt != 4'd0) begin
        check("gnt_without_send", 32'(gnt), 32'd0);
      end
      if (busy_prev && !busy) begin
        if (end_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_end: busy fell with no transfer expected at %0t", $time);
        end else begin
          f = end_q.pop_front();
          check("tx_err", 32'(tx_err), 32'(f[16]));
          check("sent_cnt", 32'(sent_cnt), 32'(f[15:0]));
        end
      end else if (tx_err) begin
        check("spurious_tx_err", 32'(tx_err), 32'd0);
      end
      busy_prev = busy;
    end
  end

  // One transfer, started at a negedge while the DUT is idle.
  // j is the WAIT cycle (0 = first WAIT cycle) in which done is pulsed; j<0 means done is never pulsed.
  task automatic do_txn(input logic [3:0] mask, input logic [31:0] data, input int tmax,
                        input int j, input bit hold, input bit drop_en);
    int w, lat;
    bit done_wins;
    logic [3:0] g;
    logic [7:0] b;
    req = mask; req_data = data; to_max_cnt = 24'(tmax); en = 1'b1;
    w = rr_pick(mask, m_ptr);
    m_ptr = (w + 1) % 4;
    g = 4'b0001 << w;
    b = data[w*8 +: 8];
    exp_q.push_back({g, b, w[1:0]});
    done_wins = (j >= 0) && (tmax == 0 || j <= tmax - 1);
    if (done_wins) m_sent = m_sent + 16'd1;
    end_q.push_back({!done_wins, m_sent});
    @(negedge mclk);
    check("grant_latency", 32'(send_en), 32'd1);
    if (!hold) req = 4'd0;
    req_data = $urandom();
    if (drop_en) en = 1'b0;
    lat = 0;
    for (int k = 1; k <= 5000; k++) begin
      @(negedge mclk);
      done = (k == j + 1);
      if (!busy) begin
        lat = k;
        break;
      end
    end
    done = 1'b0;
    check("done_latency", 32'(lat), done_wins ? 32'(j + 2) : 32'(tmax + 1));
    check("tr_data_hold", 32'(tr_data), 32'(b));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int tm, jj;
    n_reset = 1'b0; en = 1'b0; req = 4'd0; req_data = 32'd0; to_max_cnt = 24'd0; done = 1'b0;
    repeat (3) @(negedge mclk);
    check("rst_gnt", 32'(gnt), 32'd0);
    check("rst_send_en", 32'(send_en), 32'd0);
    check("rst_tr_data", 32'(tr_data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_last_id", 32'(last_id), 32'd0);
    check("rst_tx_err", 32'(tx_err), 32'd0);
    check("rst_sent_cnt", 32'(sent_cnt), 32'd0);
    n_reset = 1'b1;
    @(negedge mclk);

    // Single transfer from requester 0.
    do_txn(4'b0001, 32'h0000_0055, 0, 5, 1'b0, 1'b0);

    // All requesters held: grants rotate.
    for (int i = 0; i < 5; i++)
      do_txn(4'b1111, 32'hA4B3_C2D1, 0, 19, (i < 4), 1'b0);

    // Timeout with no done.
    do_txn(4'b0100, 32'h0011_2233, 100, -1, 1'b0, 1'b0);
    // done on the timeout cycle, then one cycle too late.
    do_txn(4'b1000, 32'h9988_7766, 30, 29, 1'b0, 1'b0);
    do_txn(4'b0010, 32'h1357_9BDF, 30, 30, 1'b0, 1'b0);
    do_txn(4'b0001, 32'h0F0F_0F0F, 1, 0, 1'b0, 1'b0);

    // done while idle is ignored.
    done = 1'b1;
    @(negedge mclk);
    done = 1'b0;
    @(negedge mclk);
    check("idle_done_sent_cnt", 32'(sent_cnt), 32'(m_sent));
    check("idle_done_busy", 32'(busy), 32'd0);

    // Enable low blocks grants; a transfer completes even if en drops during WAIT.
    en = 1'b0; req = 4'b0100; req_data = 32'h00AB_0000;
    repeat (5) @(negedge mclk);
    check("en_low_busy", 32'(busy), 32'd0);
    do_txn(4'b0100, 32'h00CD_0000, 0, 7, 1'b0, 1'b1);
    en = 1'b1;

    // Reset in the middle of WAIT, with req 0010 still pending.
    req = 4'b0010; req_data = 32'h0000_7700;
    w_reset_txn();
    check("mid_rst_gnt", 32'(gnt), 32'd0);
    check("mid_rst_send_en", 32'(send_en), 32'd0);
    check("mid_rst_tr_data", 32'(tr_data), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_last_id", 32'(last_id), 32'd0);
    check("mid_rst_tx_err", 32'(tx_err), 32'd0);
    check("mid_rst_sent_cnt", 32'(sent_cnt), 32'd0);
    m_ptr = 0; m_sent = 16'd0;
    n_reset = 1'b1;
    do_txn(4'b1010, 32'h4400_3300, 0, 2, 1'b0, 1'b0);

    // Randomised transfers.
    for (int i = 0; i < 30; i++) begin
      tm = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 40));
      jj = (tm == 0) ? int'($urandom_range(0, 30)) : int'($urandom_range(0, tm + 3));
      do_txn(4'($urandom_range(1, 15)), $urandom(), tm, jj, 1'b0, 1'b0);
      repeat ($urandom_range(0, 3)) @(negedge mclk);
    end

    repeat (5) @(negedge mclk);
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    check("end_q_drained", 32'(end_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Starts a grant to requester 1 and resets the DUT three cycles into WAIT.
  task automatic w_reset_txn();
    int w;
    logic [3:0] g;
    en = 1'b1;
    w = rr_pick(req, m_ptr);
    g = 4'b0001 << w;
    exp_q.push_back({g, req_data[w*8 +: 8], w[1:0]});
    @(negedge mclk);
    check("rst_txn_grant_latency", 32'(send_en), 32'd1);
    repeat (3) @(negedge mclk);
    n_reset = 1'b0;
    @(negedge mclk);
  endtask

endmodule
